// File: rtl/nes_controller_reader.sv
// nes_controller_reader
//   Polls an NES gamepad once per frame over its latch/clock/data interface
//   and presents the eight buttons as an active-high byte.
//
//   Parameters
//     halfPeriod   : pixelClock cycles per nesClock low or high phase (4..65535)
//
//   Ports
//     pixelClock   : system clock, rising edge
//     reset        : synchronous, active-high
//     vSyncStart   : one-cycle frame-start pulse, starts a poll when idle
//     nesData      : serial data from the pad, asynchronous, 0 = pressed
//     nesLatch     : latch strobe to the pad, active-high
//     nesClock     : shift clock to the pad, idles low
//     buttons      : button states, 1 = pressed, bit positions per button* below
//     buttonsValid : one-cycle pulse on the cycle buttons has just updated
//     busy         : high while a poll is in progress
module nes_controller_reader #(
  parameter logic [15:0] halfPeriod = 16'd240
) (
  input  logic       pixelClock,
  input  logic       reset,
  input  logic       vSyncStart,
  input  logic       nesData,
  output logic       nesLatch,
  output logic       nesClock,
  output logic [7:0] buttons,
  output logic       buttonsValid,
  output logic       busy
);

  localparam logic [2:0] buttonA      = 3'd0;
  localparam logic [2:0] buttonB      = 3'd1;
  localparam logic [2:0] buttonSelect = 3'd2;
  localparam logic [2:0] buttonStart  = 3'd3;
  localparam logic [2:0] buttonUp     = 3'd4;
  localparam logic [2:0] buttonDown   = 3'd5;
  localparam logic [2:0] buttonLeft   = 3'd6;
  localparam logic [2:0] buttonRight  = 3'd7;

  // Serial position (order the pad shifts bits out) -> bit of buttons.
  localparam logic [7:0][2:0] SERIAL_TO_INDEX = {
    buttonRight, buttonLeft, buttonDown, buttonUp,
    buttonStart, buttonSelect, buttonB, buttonA
  };

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_phase;
  logic [15:0] w_phase;
  logic [2:0]  r_index;
  logic [2:0]  w_index;
  logic        r_half;
  logic        w_half;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift;
  logic        w_load;
  logic        w_phase_end;

  logic        r_sync1;
  logic        r_sync2;
  logic        r_latch;
  logic        r_clk;
  logic [7:0]  r_buttons;
  logic        r_valid;
  logic        r_busy;

  assign w_phase_end = (r_phase == 16'd1);

  // The latch pulse spans two half periods; it is timed as two back-to-back
  // halfPeriod phases (r_half) so the 16-bit counter never has to hold
  // 2*halfPeriod, which can exceed 16 bits.
  always_comb begin
    w_next  = r_state;
    w_phase = r_phase - 16'd1;
    w_index = r_index;
    w_half  = r_half;
    w_shift = r_shift;
    w_load  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_phase = r_phase;
        if (vSyncStart) begin
          w_next  = LATCH;
          w_phase = halfPeriod;
          w_half  = 1'b0;
          w_shift = '0;
        end
      end
      LATCH: begin
        if (w_phase_end) begin
          w_phase = halfPeriod;
          if (!r_half) begin
            w_half = 1'b1;
          end else begin
            w_next  = LOW;
            w_index = '0;
          end
        end
      end
      LOW: begin
        if (w_phase_end) begin
          // Sample at the very end of the low phase, just before the pad
          // is told to shift.
          w_shift[SERIAL_TO_INDEX[r_index]] = ~r_sync2;
          w_phase = halfPeriod;
          if (r_index == 3'd7) begin
            w_next = DONE;
          end else begin
            w_next = HIGH;
          end
        end
      end
      HIGH: begin
        if (w_phase_end) begin
          w_phase = halfPeriod;
          w_index = r_index + 3'd1;
          w_next  = LOW;
        end
      end
      DONE: begin
        w_next = IDLE;
        w_load = 1'b1;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge pixelClock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_phase   <= '0;
      r_index   <= '0;
      r_half    <= 1'b0;
      r_shift   <= '0;
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_latch   <= 1'b0;
      r_clk     <= 1'b0;
      r_buttons <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_phase <= w_phase;
      r_index <= w_index;
      r_half  <= w_half;
      r_shift <= w_shift;
      r_sync1 <= nesData;
      r_sync2 <= r_sync1;
      // Outputs are registered from the next state so they line up with
      // the state register.
      r_latch <= (w_next == LATCH);
      r_clk   <= (w_next == HIGH);
      r_busy  <= (w_next != IDLE);
      r_valid <= w_load;
      if (w_load) begin
        r_buttons <= r_shift;
      end
    end
  end

  assign nesLatch     = r_latch;
  assign nesClock     = r_clk;
  assign buttons      = r_buttons;
  assign buttonsValid = r_valid;
  assign busy         = r_busy;

endmodule

// File: tb/tb_nes_controller_reader.sv
module tb_nes_controller_reader;

  localparam logic [15:0] HP = 16'd4;
  localparam int H = 4;
  localparam int BUSY_CYCLES = 17 * H + 1;   // 69
  localparam int VALID_EDGES = 17 * H + 1;   // edges after the one sampling vSyncStart

  logic       pixelClock = 1'b0;
  logic       reset;
  logic       vSyncStart;
  logic       nesData;
  logic       nesLatch;
  logic       nesClock;
  logic [7:0] buttons;
  logic       buttonsValid;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Pad model: latch loads the inverted press mask, each nesClock rise
  // shifts toward bit 0, ones fill in behind.
  logic [7:0] pad_pressed = 8'h00;
  logic [7:0] pad_sr = 8'hFF;
  logic       pad_present = 1'b1;
  logic       glitch = 1'b0;
  logic       glitch_en = 1'b0;

  // Measurements from run_poll
  int         m_latch_hi;
  int         m_latch_rises;
  int         m_clk_rises;
  int         m_clk_badw;
  int         m_busy;
  int         m_valid_cnt;
  int         m_valid_k;
  logic [7:0] m_btn;
  bit         m_early;

  always #5 pixelClock = ~pixelClock;

  nes_controller_reader #(
    .halfPeriod(HP)
  ) dut (
    .pixelClock  (pixelClock),
    .reset       (reset),
    .vSyncStart  (vSyncStart),
    .nesData     (nesData),
    .nesLatch    (nesLatch),
    .nesClock    (nesClock),
    .buttons     (buttons),
    .buttonsValid(buttonsValid),
    .busy        (busy)
  );

  always @(posedge nesLatch or posedge nesClock) begin
    if (nesLatch) pad_sr <= ~pad_pressed;
    else          pad_sr <= {1'b1, pad_sr[7:1]};
  end

  assign nesData = pad_present ? (pad_sr[0] ^ glitch) : 1'b1;

  // One-cycle data glitch in the middle of each high phase.
  always @(posedge nesClock) begin
    if (glitch_en) begin
      repeat (2) @(posedge pixelClock);
      #3 glitch <= 1'b1;
      @(posedge pixelClock);
      #3 glitch <= 1'b0;
    end
  end

  // Stimulus/measurement only: pulses vSyncStart and observes a fixed window.
  task automatic run_poll(input logic [7:0] pressed, input logic [7:0] prev_btn,
                          input int resync_at);
    logic pl;
    logic pc;
    int   w;
    pad_pressed   = pressed;
    m_latch_hi    = 0;
    m_latch_rises = 0;
    m_clk_rises   = 0;
    m_clk_badw    = 0;
    m_busy        = 0;
    m_valid_cnt   = 0;
    m_valid_k     = -1;
    m_btn         = 8'h00;
    m_early       = 1'b0;
    pl = 1'b0;
    pc = 1'b0;
    w  = 0;
    @(negedge pixelClock);
    vSyncStart = 1'b1;
    for (int k = 1; k <= 110; k++) begin
      @(negedge pixelClock);
      vSyncStart = (k == resync_at);
      if (nesLatch) m_latch_hi++;
      if (nesLatch && !pl) m_latch_rises++;
      if (nesClock && !pc) begin
        m_clk_rises++;
        w = 1;
      end else if (nesClock) begin
        w++;
      end else if (pc) begin
        if (w != H) m_clk_badw++;
      end
      if (busy) m_busy++;
      if (buttonsValid) begin
        m_valid_cnt++;
        if (m_valid_k < 0) begin
          m_valid_k = k;
          m_btn     = buttons;
        end
      end else if (m_valid_k < 0 && buttons !== prev_btn) begin
        m_early = 1'b1;
      end
      pl = nesLatch;
      pc = nesClock;
    end
    vSyncStart = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    vSyncStart = 1'b0;
    repeat (3) @(negedge pixelClock);
    checks++; if (nesLatch !== 1'b0) begin errors++; $display("FAIL reset_latch got %b expected 0", nesLatch); end
    checks++; if (nesClock !== 1'b0) begin errors++; $display("FAIL reset_clock got %b expected 0", nesClock); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (buttonsValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", buttonsValid); end
    checks++; if (buttons !== 8'h00) begin errors++; $display("FAIL reset_buttons got %h expected 00", buttons); end
    reset = 1'b0;
    repeat (3) @(negedge pixelClock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b expected 0", busy); end
  endtask

  task automatic test_timing();
    pad_present = 1'b1;
    run_poll(8'h00, 8'h00, 0);
    checks++; if (m_latch_hi != 2 * H) begin errors++; $display("FAIL latch_width got %0d expected %0d", m_latch_hi, 2 * H); end
    checks++; if (m_latch_rises != 1) begin errors++; $display("FAIL latch_count got %0d expected 1", m_latch_rises); end
    checks++; if (m_clk_rises != 7) begin errors++; $display("FAIL clock_pulses got %0d expected 7", m_clk_rises); end
    checks++; if (m_clk_badw != 0) begin errors++; $display("FAIL clock_width bad pulses %0d expected 0", m_clk_badw); end
    checks++; if (m_busy != BUSY_CYCLES) begin errors++; $display("FAIL busy_len got %0d expected %0d", m_busy, BUSY_CYCLES); end
    checks++; if (m_valid_cnt != 1) begin errors++; $display("FAIL valid_count got %0d expected 1", m_valid_cnt); end
    checks++; if (m_valid_k - 1 != VALID_EDGES) begin errors++; $display("FAIL valid_time got %0d expected %0d", m_valid_k - 1, VALID_EDGES); end
    checks++; if (m_btn !== 8'h00) begin errors++; $display("FAIL released_buttons got %h expected 00", m_btn); end
  endtask

  task automatic test_pad_absent();
    pad_present = 1'b0;
    run_poll(8'hFF, 8'h00, 0);
    pad_present = 1'b1;
    checks++; if (m_valid_cnt != 1) begin errors++; $display("FAIL absent_valid got %0d expected 1", m_valid_cnt); end
    checks++; if (m_btn !== 8'h00) begin errors++; $display("FAIL absent_buttons got %h expected 00", m_btn); end
  endtask

  task automatic test_decode();
    run_poll(8'h11, 8'h00, 0);
    checks++; if (m_btn !== 8'h11) begin errors++; $display("FAIL decode_buttons got %h expected 11", m_btn); end
    checks++; if (m_btn[4] !== 1'b1) begin errors++; $display("FAIL decode_up got %b expected 1", m_btn[4]); end
    checks++; if (m_btn[0] !== 1'b1) begin errors++; $display("FAIL decode_a got %b expected 1", m_btn[0]); end
    repeat (20) @(negedge pixelClock);
    checks++; if (buttons !== 8'h11) begin errors++; $display("FAIL decode_hold got %h expected 11", buttons); end
  endtask

  task automatic test_atomic();
    run_poll(8'h80, 8'h11, 0);
    checks++; if (m_early !== 1'b0) begin errors++; $display("FAIL atomic_early changed before valid got %b expected 0", m_early); end
    checks++; if (m_btn !== 8'h80) begin errors++; $display("FAIL atomic_buttons got %h expected 80", m_btn); end
  endtask

  task automatic test_back_to_back();
    run_poll(8'h80, 8'h80, 20);
    checks++; if (m_latch_rises != 1) begin errors++; $display("FAIL ignore_latch got %0d expected 1", m_latch_rises); end
    checks++; if (m_busy != BUSY_CYCLES) begin errors++; $display("FAIL ignore_busy got %0d expected %0d", m_busy, BUSY_CYCLES); end
    checks++; if (m_valid_cnt != 1) begin errors++; $display("FAIL ignore_valid got %0d expected 1", m_valid_cnt); end
    checks++; if (m_clk_rises != 7) begin errors++; $display("FAIL ignore_clocks got %0d expected 7", m_clk_rises); end
  endtask

  task automatic test_async_walk();
    logic [7:0] prev;
    logic [7:0] exp;
    prev      = 8'h80;
    glitch_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = 8'(1 << i);
      run_poll(exp, prev, 0);
      checks++; if (m_btn !== exp) begin errors++; $display("FAIL walk_%0d got %h expected %h", i, m_btn, exp); end
      prev = exp;
    end
    glitch_en = 1'b0;
  endtask

  task automatic test_reset_mid_poll();
    logic pc;
    int   rises;
    bit   found;
    int   vcnt;
    int   bcnt;
    pad_pressed = 8'h3C;
    pc    = 1'b0;
    rises = 0;
    found = 1'b0;
    @(negedge pixelClock);
    vSyncStart = 1'b1;
    @(negedge pixelClock);
    vSyncStart = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge pixelClock);
      if (nesClock && !pc) rises++;
      pc = nesClock;
      if (rises == 4) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL midpoll_reach bit3 high not seen got %0d rises expected 4", rises); end
    reset = 1'b1;
    repeat (3) @(negedge pixelClock);
    reset = 1'b0;
    checks++; if (nesLatch !== 1'b0) begin errors++; $display("FAIL midpoll_latch got %b expected 0", nesLatch); end
    checks++; if (nesClock !== 1'b0) begin errors++; $display("FAIL midpoll_clock got %b expected 0", nesClock); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midpoll_busy got %b expected 0", busy); end
    checks++; if (buttons !== 8'h00) begin errors++; $display("FAIL midpoll_buttons got %h expected 00", buttons); end
    vcnt = 0;
    bcnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge pixelClock);
      if (buttonsValid) vcnt++;
      if (busy) bcnt++;
    end
    checks++; if (vcnt != 0) begin errors++; $display("FAIL midpoll_novalid got %0d expected 0", vcnt); end
    checks++; if (bcnt != 0) begin errors++; $display("FAIL midpoll_idle busy cycles %0d expected 0", bcnt); end
    checks++; if (buttons !== 8'h00) begin errors++; $display("FAIL midpoll_hold got %h expected 00", buttons); end
  endtask

  task automatic test_reset_vsync_collision();
    int bcnt;
    int lcnt;
    @(negedge pixelClock);
    reset      = 1'b1;
    vSyncStart = 1'b1;
    @(negedge pixelClock);
    reset      = 1'b0;
    vSyncStart = 1'b0;
    bcnt = 0;
    lcnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge pixelClock);
      if (busy) bcnt++;
      if (nesLatch) lcnt++;
    end
    checks++; if (bcnt != 0) begin errors++; $display("FAIL collide_busy got %0d expected 0", bcnt); end
    checks++; if (lcnt != 0) begin errors++; $display("FAIL collide_latch got %0d expected 0", lcnt); end
    run_poll(8'h24, 8'h00, 0);
    checks++; if (m_btn !== 8'h24) begin errors++; $display("FAIL recover_buttons got %h expected 24", m_btn); end
  endtask

  initial begin
    reset      = 1'b1;
    vSyncStart = 1'b0;
    test_reset();
    test_timing();
    test_pad_absent();
    test_decode();
    test_atomic();
    test_back_to_back();
    test_async_walk();
    test_reset_mid_poll();
    test_reset_vsync_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nes_controller_reader.md
Name: nes_controller_reader

Overview:
Polls a standard NES gamepad over its 3-wire serial interface (latch, clock, data) once per video frame. It presents the 8 button states as an active-high parallel byte. It is the producer of the `buttons[7:0]` bus consumed by the paddle and other game-logic blocks, which index it with this block's button-index localparams. It runs in the pixel clock domain and is kicked off by the VGA timing block's frame-start pulse.

Parameters:
halfPeriod, 16'd240, length in pixelClock cycles of one clock-low or clock-high phase (6 us at 40 MHz); legal range 4..65535.
Button-index localparams (exported, fixed): buttonA=0, buttonB=1, buttonSelect=2, buttonStart=3, buttonUp=4, buttonDown=5, buttonLeft=6, buttonRight=7.

Ports:
pixelClock  in  1  system clock; all logic on its rising edge.
reset  in  1  synchronous, active-high reset.
vSyncStart  in  1  one-cycle frame-start pulse; requests a poll.
nesData  in  1  serial data from pad; asynchronous, active-low (0 = pressed).
nesLatch  out  1  latch strobe to pad, active-high.
nesClock  out  1  shift clock to pad; idles low, pad shifts on rising edge.
buttons  out  8  debounced-by-frame button states, 1 = pressed, indexed by the localparams.
buttonsValid  out  1  one-cycle pulse when `buttons` has just been updated.
busy  out  1  high while a poll is in progress (any state except IDLE).

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - State goes to IDLE.
  - nesLatch=0, nesClock=0, buttons=8'h00, buttonsValid=0, busy=0.
  - Shift register, bit index and phase counter are cleared.
  - A reset mid-poll aborts the poll immediately; `buttons` is not partially updated.
- nesData passes through a 2-flop synchronizer (reset to 1 = released) before any use.
- Phase counter: 16-bit. Loaded at each state entry, decremented each cycle. The phase ends on the cycle the counter equals 1.
- State machine:
  - IDLE:
    - nesLatch=0, nesClock=0.
    - vSyncStart=1 → LATCH.
    - vSyncStart while not in IDLE is ignored (no queuing).
  - LATCH:
    - nesLatch=1 for exactly 2*halfPeriod cycles, then → LOW with bit index=0.
  - LOW:
    - nesLatch=0, nesClock=0 for halfPeriod cycles.
    - On the final cycle, shift[index] <= ~syncData.
    - If index==7 → DONE; else → HIGH.
  - HIGH:
    - nesClock=1 for halfPeriod cycles, then index <= index+1 → LOW.
  - DONE (1 cycle):
    - buttons <= shift register (all 8 bits update atomically); buttonsValid=1 on the following cycle for exactly one cycle.
    - → IDLE.
- Pulse and poll timing:
  - Exactly 1 latch pulse and 7 nesClock high pulses per poll.
  - Total busy duration is 17*halfPeriod + 1 cycles, measured from the cycle after vSyncStart.
- Constraints:
  - The poll must complete within one frame.
  - busy is registered: high from the cycle after vSyncStart through the DONE cycle.
- Pad absent (nesData floats high): buttons read 8'h00.
- Simultaneous reset and vSyncStart: reset wins; no poll starts.
- buttons holds its value between polls; it changes only in DONE or on reset.

Test Plan:
- Reset: hold reset 3 cycles mid-poll (during HIGH of bit 3) → next cycle nesLatch=0, nesClock=0, busy=0, buttons=8'h00, no buttonsValid pulse.
- Timing, halfPeriod=4, pad model returning all released: pulse vSyncStart →
  - nesLatch high for 8 cycles;
  - then exactly 7 nesClock high pulses, each 4 cycles wide;
  - buttonsValid pulses once 69 cycles after vSyncStart; buttons=8'h00.
- Decode: pad model presses Up and A (serial stream A,B,Sel,Start,Up,Down,Left,Right = 0,1,1,1,0,1,1,1) → buttons=8'h11 with buttonsValid; bits buttonUp=1, buttonA=1.
- Atomic update: previous buttons=8'h11, next poll with Right only → buttons stays 8'h11 throughout the poll, becomes 8'h80 exactly at buttonsValid.
- Busy/ignore: issue vSyncStart again 20 cycles into a poll → no restart, latch pulses once, busy duration still 69 cycles.
- Asynchronous data: toggle nesData away from the sample points (mid HIGH phase) → sampled values unaffected; all 8 patterns of walking-one press decode to buttons = 1<<index.
